// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one GPIO register-slave port among NUM_REQ requesters.
// One transaction at a time: IDLE -> ISSUE -> (RWAIT) -> ACK, with optional owner lock for RMW.
module gpio_bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    lock,
    input  logic [NUM_REQ-1:0]    we,
    input  logic [3*NUM_REQ-1:0]  addr,
    input  logic [32*NUM_REQ-1:0] wdata,
    output logic [NUM_REQ-1:0]    ack,
    output logic [31:0]           rdata,
    output logic [IDX_W-1:0]      owner,
    output logic                  busy,
    output logic [2:0]            m_address,
    output logic                  m_chipselect,
    output logic                  m_write_n,
    output logic [31:0]           m_writedata,
    input  logic [31:0]           m_readdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, ACK} state_t;

    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

    state_t               state;
    logic [IDX_W-1:0]     cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0]   owner_onehot;
    logic [IDX_W-1:0]     winner;
    logic                 any_req;

    // Candidate k is the requester k+1 places above the owner, wrapping; the last one is the owner itself.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IDX_W:0] cand_sum;
            logic [IDX_W:0] cand_wrap;
            assign cand_sum     = {1'b0, owner} + (IDX_W+1)'(gi + 1);
            assign cand_wrap    = (cand_sum >= NUM_REQ_W) ? (cand_sum - NUM_REQ_W) : cand_sum;
            assign cand_idx[gi] = IDX_W'(cand_wrap);
            assign owner_onehot[gi] = (owner == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        winner  = owner;
        any_req = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                winner = cand_idx[k];
            end
        end
        if (req[owner] && lock[owner]) begin
            winner = owner;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ack          <= '0;
            rdata        <= '0;
            busy         <= 1'b0;
            owner        <= IDX_W'(NUM_REQ - 1);
            m_address    <= 3'd0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_writedata  <= 32'd0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner        <= winner;
                        m_address    <= addr[3*int'(winner) +: 3];
                        m_writedata  <= wdata[32*int'(winner) +: 32];
                        m_write_n    <= ~we[winner];
                        m_chipselect <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    m_chipselect <= 1'b0;
                    m_write_n    <= 1'b1;
                    // m_write_n still carries the latched command during ISSUE.
                    if (!m_write_n) begin
                        ack   <= owner_onehot;
                        state <= ACK;
                    end else begin
                        state <= RWAIT;
                    end
                end
                RWAIT: begin
                    rdata <= m_readdata;
                    ack   <= owner_onehot;
                    state <= ACK;
                end
                ACK: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
